// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Provides the fetch FSM state type, PC increment and default encodings.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  localparam int PC_STEP = 4;

  localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_unit_if_id.sv
// if_id_register: IF/ID boundary register (instr, instr_pc, instr_valid).
// Ports: clk, reset (async active-low), load, flush, data, pc -> instr, instr_pc, instr_valid.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int            W        = 32,
  parameter logic [W-1:0]  NOP_WORD = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] data,
  input  logic [W-1:0] pc,
  output logic [W-1:0] instr,
  output logic [W-1:0] instr_pc,
  output logic         instr_valid
);

  // Flush wins over load; instr_pc is left alone on a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr       <= NOP_WORD;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - PC, BOOT/RUN/HALTED FSM, fetch counter, misaligned flag.
// Ports: clk, reset, stall, redirect, target, imem_data -> imem_address, instr*, halted, misaligned, fetch_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              bus       = 32,
  parameter logic [bus-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [bus-1:0]  HALT_WORD = DEF_HALT_WORD,
  parameter logic [bus-1:0]  NOP_WORD  = DEF_NOP_WORD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           redirect,
  input  logic [bus-1:0] target,
  output logic [bus-1:0] imem_address,
  input  logic [bus-1:0] imem_data,
  output logic [bus-1:0] instr,
  output logic [bus-1:0] instr_pc,
  output logic           instr_valid,
  output logic           halted,
  output logic           misaligned,
  output logic [31:0]    fetch_count
);

  localparam logic [bus-1:0] STEP = bus'(PC_STEP);

  fetch_state_t   state;
  fetch_state_t   state_next;
  logic [bus-1:0] pc;
  logic [bus-1:0] pc_next;
  logic           load;
  logic           flush;
  logic           count_en;
  logic           mis_set;

  assign imem_address = pc;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    count_en   = 1'b0;
    mis_set    = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect) begin
          pc_next = {target[bus-1:2], 2'b00};
          flush   = 1'b1;
          mis_set = |target[1:0];
        end else if (!stall) begin
          load     = 1'b1;
          count_en = 1'b1;
          if (imem_data == HALT_WORD) begin
            state_next = HALTED;
          end else begin
            pc_next = pc + STEP;
          end
        end
      end
      // Halted: keep the PC and drain IF/ID to a bubble.
      HALTED: flush = 1'b1;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
      halted      <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      halted     <= (state_next == HALTED);
      misaligned <= misaligned | mis_set;
      if (count_en) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_register #(
    .W        (bus),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .data        (imem_data),
    .pc          (pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the CPU: owns the program counter, drives the word-aligned byte address into `InstructionMemory`, and registers the returned word into the IF/ID boundary with its PC and a valid bit. Handles pipeline stall, branch redirect/flush, halt detection and a retired-fetch counter. Sits between `InstructionMemory` (upstream data source) and the decode stage (downstream consumer).

## Interface
- `bus`, 32, datapath and address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `NOP_WORD`, 32'h0000_0000, value placed in `instr` on reset and on flush.
- `clk`  in  1  system clock; the block acts on posedge only.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `stall`  in  1  hold PC and IF/ID contents.
- `redirect`  in  1  taken branch/jump; load `target`, flush IF/ID.
- `target`  in  bus  redirect byte address.
- `imem_address`  out  bus  byte address to `InstructionMemory.address`; equals `pc` combinationally.
- `imem_data`  in  bus  word from `InstructionMemory.data`.
- `instr`  out  bus  IF/ID instruction.
- `instr_pc`  out  bus  byte address of `instr`.
- `instr_valid`  out  1  `instr` is a real fetched instruction.
- `halted`  out  1  fetch stopped on `HALT_WORD`.
- `misaligned`  out  1  sticky: a redirect target had `target[1:0]!=0`.
- `fetch_count`  out  32  count of instructions delivered with `instr_valid=1`.

## Operation
- States: BOOT, RUN, HALTED. Reset -> BOOT.
- Reset values: `pc=RESET_PC`, `instr=NOP_WORD`, `instr_pc=0`, `instr_valid=0`, `halted=0`, `misaligned=0`, `fetch_count=0`.
- BOOT: one posedge with no capture, PC unchanged, then -> RUN. Guarantees memory has performed a full negedge read of `RESET_PC`.
- RUN, per posedge, priority order:
  - `redirect`: `pc <= {target[bus-1:2],2'b00}`; `instr<=NOP_WORD`, `instr_valid<=0`; `misaligned<=1` if `target[1:0]!=0`. Overrides `stall` and halt detection.
  - `stall`: all registers hold (including `instr_valid`, `fetch_count`).
  - else capture: `instr<=imem_data`, `instr_pc<=pc`, `instr_valid<=1`, `fetch_count++`; if `imem_data==HALT_WORD` -> HALTED, `pc` held; otherwise `pc<=pc+4`.
- HALTED: `halted=1`; `pc` frozen; next posedge `instr_valid<=0`, `instr<=NOP_WORD`; `stall`/`redirect` ignored; exit only via reset.
- Arithmetic: `pc+4` modulo 2^bus (0xFFFF_FFFC -> 0x0000_0000); `fetch_count` wraps modulo 2^32.
- `halted` and `misaligned` are registered outputs.

## Timing
- `imem_address` changes only just after posedge; memory samples it at the following negedge; `imem_data` is stable by the next posedge.
- Fetch latency: PC value P present in cycle N -> `instr`/`instr_pc=P`/`instr_valid=1` visible after posedge ending cycle N (one cycle).
- Redirect: asserted in cycle N -> bubble (`instr_valid=0`) after that edge; instruction at target valid one cycle later.
- Stall over k cycles: outputs held k cycles; no instruction skipped or duplicated.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronously), regardless of clock; release is sampled at the next posedge into BOOT.

## Structure
- Package `fetch_pkg`: `typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t`, `PC_STEP=4`, default `NOP_WORD`/`HALT_WORD` constants.
- Sub-module `if_id_register`: holds `instr`, `instr_pc`, `instr_valid` with load/hold/flush controls and async active-low reset; `fetch_unit` contains PC, FSM, counter, sticky flag.

## Test plan
- Reset release, memory {0x0:0xE3A00001, 0x4:0xE3A01002, 0x8:0xFFFFFFFF} -> BOOT cycle valid=0; then (0x0,0xE3A00001),(0x4,0xE3A01002),(0x8,0xFFFFFFFF) valid; `halted=1`, `fetch_count=3`, `imem_address` stays 0x8.
- Stall 3 cycles while `instr_pc=0x4` -> outputs and `fetch_count` unchanged 3 cycles; next capture `instr_pc=0x8`.
- `redirect=1`, `target=0x40` with `stall=1` same cycle -> `instr_valid=0`, `instr=NOP_WORD`; next cycle `instr_pc=0x40`.
- `redirect` with `target=0x42` -> fetch from 0x40, `misaligned=1`, remains 1 until reset.
- `redirect` in the same cycle `HALT_WORD` arrives -> not halted, `fetch_count` unchanged, fetch resumes at target; `RESET_PC=0xFFFF_FFFC` -> second fetch `instr_pc=0x0`.
- Drop `reset` low mid-run between edges -> all outputs at reset values before next posedge; restart from `RESET_PC` via BOOT.
